// File: rtl/glitch_pkg.sv
// Shared types and defaults for the glitch sequencer.
//   glitch_state_t : sequencer FSM states
//   glitch_cfg_t   : config captured on arm; fields sized to the package defaults, which are
//                    the largest widths the sequencer accepts
package glitch_pkg;

  localparam int unsigned FormWDef  = 64;
  localparam int unsigned DelayWDef = 32;
  localparam int unsigned RepWDef   = 8;
  localparam int unsigned GapWDef   = 16;

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, FIRE, GAP} glitch_state_t;

  typedef struct packed {
    logic                 pol;
    logic [FormWDef-1:0]  form;
    logic [DelayWDef-1:0] delay;
    logic [RepWDef-1:0]   reps;
    logic [GapWDef-1:0]   gap;
  } glitch_cfg_t;

endpackage

// File: rtl/glitch_serializer.sv
// LSB-first waveform serializer.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : start a new word; bit_o presents data_i[0] this cycle
//   shift_i       : advance to the next bit
//   data_i        : word to serialize
//   bit_o         : bit to be registered by the caller this cycle
module glitch_serializer #(
  parameter int unsigned FORM_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [FORM_W-1:0] data_i,
  output logic              bit_o
);

  // Holds the bits still to be emitted; bit 0 is always the next one.
  logic [FORM_W-1:0] shreg_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i >> 1;
    end else if (shift_i) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  always_comb begin
    bit_o = load_i ? data_i[0] : shreg_q[0];
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Armed, trigger-driven glitch waveform sequencer.
// Arms on `arm` (latching config), waits for a trigger edge of the latched polarity, waits
// `delay` cycles, then emits `form` LSB-first, repeated max(reps,1) times separated by `gap`
// low cycles. Ends with a one-cycle `done` pulse.
//   clk, rst_n            : clock, synchronous active-low reset
//   arm, abort            : start request (IDLE only) / immediate return to IDLE
//   trig, trig_pol        : synchronised trigger, 1 = rising edge active
//   form, delay, reps, gap: sequence config, captured on arm
//   out, busy, done       : registered glitch output and status
// Optional: define GLITCH_SHOT_CNT_EN to add shot_cnt[31:0], counting done pulses.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned FORM_W  = FormWDef,
  parameter int unsigned DELAY_W = DelayWDef,
  parameter int unsigned REP_W   = RepWDef,
  parameter int unsigned GAP_W   = GapWDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig,
  input  logic               trig_pol,
  input  logic [FORM_W-1:0]  form,
  input  logic [DELAY_W-1:0] delay,
  input  logic [REP_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               out,
  output logic               busy,
  output logic               done
`ifdef GLITCH_SHOT_CNT_EN
  ,
  output logic [31:0]        shot_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(FORM_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FORM_W - 1);

  // Config storage is sized by the package; wider parameters cannot be held.
  if (FORM_W > FormWDef || DELAY_W > DelayWDef || REP_W > RepWDef || GAP_W > GapWDef ||
      FORM_W < 2) begin : g_bad_param
    $error("glitch_sequencer: parameter outside supported range");
  end

  glitch_state_t      state_q;
  glitch_cfg_t        cfg_q, cfg_d;
  logic               trig_q;
  logic               out_q, busy_q, done_q;
  logic [DELAY_W-1:0] dly_q;
  logic [IdxW-1:0]    idx_q;
  logic [REP_W-1:0]   rep_q;
  logic [GAP_W-1:0]   gap_q;

  logic               cfg_pol;
  logic [FORM_W-1:0]  cfg_form;
  logic [DELAY_W-1:0] cfg_delay;
  logic [REP_W-1:0]   cfg_reps;
  logic [GAP_W-1:0]   cfg_gap;
  logic               trig_edge;
  logic               ser_load, ser_shift, ser_bit;

  always_comb begin
    cfg_d       = '0;
    cfg_d.pol   = trig_pol;
    cfg_d.form  = FormWDef'(form);
    cfg_d.delay = DelayWDef'(delay);
    cfg_d.reps  = RepWDef'(reps);
    cfg_d.gap   = GapWDef'(gap);
  end

  always_comb begin
    cfg_pol   = cfg_q.pol;
    cfg_form  = cfg_q.form[FORM_W-1:0];
    cfg_delay = cfg_q.delay[DELAY_W-1:0];
    cfg_reps  = cfg_q.reps[REP_W-1:0];
    cfg_gap   = cfg_q.gap[GAP_W-1:0];
    trig_edge = cfg_pol ? (trig & ~trig_q) : (~trig & trig_q);
  end

  // A burst starts when the delay or gap expires, or straight after the previous burst when
  // gap is zero.
  always_comb begin
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    if (!abort) begin
      unique case (state_q)
        DELAY:   ser_load = (dly_q == '0);
        GAP:     ser_load = (gap_q == '0);
        FIRE: begin
          ser_shift = (idx_q != LastIdx);
          ser_load  = (idx_q == LastIdx) && (rep_q != REP_W'(1)) && (cfg_gap == '0);
        end
        default: ;
      endcase
    end
  end

  glitch_serializer #(
    .FORM_W (FORM_W)
  ) u_serializer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .data_i  (cfg_form),
    .bit_o   (ser_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      trig_q  <= trig;  // no false edge right after reset
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dly_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      trig_q <= trig;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (arm) begin
              cfg_q   <= cfg_d;
              busy_q  <= 1'b1;
              state_q <= ARMED;
            end
          end
          ARMED: begin
            if (trig_edge) begin
              dly_q   <= cfg_delay;
              rep_q   <= (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
              state_q <= DELAY;
            end
          end
          DELAY: begin
            if (dly_q == '0) begin
              out_q   <= ser_bit;
              idx_q   <= '0;
              state_q <= FIRE;
            end else begin
              dly_q <= dly_q - DELAY_W'(1);
            end
          end
          FIRE: begin
            if (idx_q != LastIdx) begin
              out_q <= ser_bit;
              idx_q <= idx_q + IdxW'(1);
            end else if (rep_q == REP_W'(1)) begin
              out_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              rep_q <= rep_q - REP_W'(1);
              idx_q <= '0;
              if (cfg_gap == '0) begin
                out_q <= ser_bit;
              end else begin
                out_q   <= 1'b0;
                gap_q   <= cfg_gap - GAP_W'(1);
                state_q <= GAP;
              end
            end
          end
          GAP: begin
            if (gap_q == '0) begin
              out_q   <= ser_bit;
              state_q <= FIRE;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef GLITCH_SHOT_CNT_EN
  logic [31:0] shot_q;

  // Counts completions only; abort leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shot_q <= '0;
    end else if (!abort && state_q == FIRE && idx_q == LastIdx && rep_q == REP_W'(1)) begin
      shot_q <= shot_q + 32'd1;
    end
  end

  assign shot_cnt = shot_q;
`endif

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised + directed bench for glitch_sequencer. Expected per-cycle outputs come from a
// timeline model (trigger cycle plus arithmetic on delay/bursts/gap), pushed into a queue
// tagged with the clock edge they apply to; a monitor pops and compares on falling edges.
module tb_glitch_sequencer;

  localparam int FW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig = 1'b0;
  logic        trig_pol = 1'b1;
  logic [63:0] form = '0;
  logic [31:0] delay = '0;
  logic [7:0]  reps = '0;
  logic [15:0] gap = '0;
  logic        out, busy, done;
`ifdef GLITCH_SHOT_CNT_EN
  logic [31:0] shot_cnt;
`endif

  glitch_sequencer u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .abort    (abort),
    .trig     (trig),
    .trig_pol (trig_pol),
    .form     (form),
    .delay    (delay),
    .reps     (reps),
    .gap      (gap),
    .out      (out),
    .busy     (busy),
    .done     (done)
`ifdef GLITCH_SHOT_CNT_EN
    ,
    .shot_cnt (shot_cnt)
`endif
  );

  always #5 clk = ~clk;

  longint edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    longint      cyc;
    logic        o;
    logic        b;
    logic        d;
    logic [31:0] shot;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: 0 idle, 1 armed, 2 running since trigger cycle m_t.
  int          m_mode = 0;
  logic        m_pol = 1'b1;
  logic [63:0] m_form = '0;
  longint      m_delay = 0, m_n = 1, m_gap = 0, m_t = 0;
  logic        m_prev = 1'b0;
  logic [31:0] m_shot = '0;

  task automatic model_step();
    exp_t   x;
    longint c, rel, span, pos;
    c = edge_cnt + 1;
    x.cyc = c;
    x.o = 1'b0;
    x.d = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      m_shot = '0;
    end else if (abort) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (arm) begin
        m_mode  = 1;
        m_pol   = trig_pol;
        m_form  = form;
        m_delay = longint'(delay);
        m_n     = (reps == 0) ? 1 : longint'(reps);
        m_gap   = longint'(gap);
      end
    end else if (m_mode == 1) begin
      if (m_pol ? (trig && !m_prev) : (!trig && m_prev)) begin
        m_mode = 2;
        m_t    = c;
      end
    end else begin
      rel  = c - (m_t + m_delay + 1);
      span = FW + m_gap;
      if (rel == m_n * FW + (m_n - 1) * m_gap) begin
        x.d    = 1'b1;
        m_mode = 0;
        m_shot = m_shot + 1;
      end else if (rel >= 0) begin
        pos = rel % span;
        if (pos < FW) x.o = m_form[int'(pos)];
      end
    end
    x.b    = (m_mode != 0);
    x.shot = m_shot;
    m_prev = trig;
    exp_q.push_back(x);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit wiggle);
    for (int i = 0; i < n; i++) begin
      if (wiggle) trig = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic do_arm(input logic pol, input logic [63:0] f, input logic [31:0] d,
                        input logic [7:0] r, input logic [15:0] g);
    trig_pol = pol; form = f; delay = d; reps = r; gap = g;
    arm = 1'b1;
    step();
    arm = 1'b0;
    // Config inputs are free to change once latched.
    trig_pol = 1'($urandom_range(0, 1));
    form = {$urandom, $urandom};
    delay = $urandom;
    reps = 8'($urandom);
    gap = 16'($urandom);
    step();
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({out, busy, done} !== {e.o, e.b, e.d}) begin
        n_errors++;
        $display("FAIL outputs edge %0d: out/busy/done got %b%b%b expected %b%b%b",
                 e.cyc, out, busy, done, e.o, e.b, e.d);
      end
`ifdef GLITCH_SHOT_CNT_EN
      n_checks++;
      if (shot_cnt !== e.shot) begin
        n_errors++;
        $display("FAIL shot_cnt edge %0d: got %0d expected %0d", e.cyc, shot_cnt, e.shot);
      end
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with trig high; no edge may be seen on release.
    trig = 1'b1;
    run(3, 1'b0);
    rst_n = 1'b1;
    trig = 1'b0;
    step();

    // Single burst, delay 10: out high at T+15..T+18, done at T+75.
    do_arm(1'b1, 64'h0000_0000_0000_00F0, 32'd10, 8'd1, 16'd0);
    trig = 1'b1;
    step();
    run(80, 1'b1);

    // Falling polarity, delay 0; a rising edge first must do nothing.
    trig = 1'b0;
    step();
    do_arm(1'b0, 64'h1, 32'd0, 8'd1, 16'd0);
    trig = 1'b1;
    run(3, 1'b0);
    trig = 1'b0;
    step();
    run(70, 1'b1);

    // Three bursts with gap 4.
    trig = 1'b0;
    step();
    do_arm(1'b1, 64'h8000_0000_0000_0001, 32'd2, 8'd3, 16'd4);
    trig = 1'b1;
    step();
    run(210, 1'b1);

    // reps=0 acts as one burst; gap=0 back-to-back is covered in the random phase.
    trig = 1'b1;
    step();
    do_arm(1'b0, {$urandom, $urandom}, 32'd3, 8'd0, 16'd5);
    trig = 1'b0;
    step();
    run(75, 1'b1);

    // Trigger activity while idle.
    run(20, 1'b1);

    // Abort during the second burst, then a full sequence.
    trig = 1'b0;
    step();
    do_arm(1'b1, {$urandom, $urandom}, 32'd1, 8'd3, 16'd2);
    trig = 1'b1;
    step();
    run(100, 1'b1);
    abort = 1'b1;
    arm = 1'b1;
    step();
    abort = 1'b0;
    arm = 1'b0;
    run(5, 1'b1);
    trig = 1'b0;
    step();
    do_arm(1'b1, {$urandom, $urandom}, 32'd4, 8'd2, 16'd0);
    trig = 1'b1;
    step();
    run(140, 1'b1);

    // Reset during DELAY with trig held high.
    trig = 1'b0;
    step();
    do_arm(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd20, 8'd1, 16'd0);
    trig = 1'b1;
    run(5, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(40, 1'b0);

    // Random sequences with stray arms, trigger noise and rare aborts.
    for (int k = 0; k < 30; k++) begin
      logic        p;
      logic [31:0] d;
      logic [7:0]  r;
      logic [15:0] g;
      int          len;
      p = 1'($urandom_range(0, 1));
      d = 32'($urandom_range(0, 15));
      r = 8'($urandom_range(0, 3));
      g = 16'($urandom_range(0, 5));
      trig = ~p;
      run(2, 1'b0);
      do_arm(p, {$urandom, $urandom}, d, r, g);
      run($urandom_range(0, 3), 1'b0);
      trig = p;
      step();
      len = int'(d) + 6 + 4 * FW + 3 * int'(g);
      for (int j = 0; j < len; j++) begin
        trig  = 1'($urandom_range(0, 1));
        arm   = ($urandom_range(0, 15) == 0);
        abort = ($urandom_range(0, 299) == 0);
        step();
      end
      arm = 1'b0;
      abort = 1'b0;
    end

    run(3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
